// File: rtl/std_skid_buf_if.sv
// Handshake bundle for std_skid_buf: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy readout.
// master = the side that drives the buffer (source and sink together),
// slave  = the buffer itself.
interface std_skid_buf_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/std_skid_buf.sv
// std_skid_buf: 2-entry valid/ready skid buffer with a main and a skid
// register. in_ready depends only on registered state (plus rst/flush),
// so the ready path between neighbouring stages is cut; beats appear on
// the output one cycle after acceptance, at full throughput.
// Optional feature: define STD_SKID_BUF_FLUSH_EN to get a flush port that
// empties the buffer without touching the data registers.
module std_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef STD_SKID_BUF_FLUSH_EN
    input  logic flush,
`endif
    std_skid_buf_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_next;
    logic             flush_now;
    logic             in_fire;
    logic             out_fire;

`ifdef STD_SKID_BUF_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Output decode: everything here is a function of registered state, rst and flush.
    always_comb begin
        bus.in_ready  = (state != FULL) && !rst && !flush_now;
        bus.out_valid = (state != EMPTY) && !rst && !flush_now;
        bus.out_data  = main_q;
        bus.count     = rst ? 2'd0 : state;
    end

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // Next-state and data-register steering; hold is the default.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush_now) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = bus.in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = bus.in_data;
                    end else if (in_fire) begin
                        state_next = FULL;
                        skid_next  = bus.in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_q;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

endmodule

// File: tb/tb_std_skid_buf.sv
// Self-checking bench for std_skid_buf. A queue models the buffer
// contents: beats are pushed when the bench offers them and the model
// has room, popped when the model says the sink takes one, and every
// cycle the DUT outputs are compared against the queue.
module tb_std_skid_buf;

    logic clk;
    logic rst;
    logic flush;

    std_skid_buf_if #(.WIDTH(8)) bus ();

    std_skid_buf #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef STD_SKID_BUF_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    logic [7:0] model_q[$];
    int         n_checks;
    int         n_pass;
    int         n_fail;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs with what the model predicts for the current inputs.
    task automatic checkOutput(input string tag);
        logic       exp_ready;
        logic       exp_valid;
        logic [1:0] exp_count;
        exp_ready = !rst && !flush && (model_q.size() < 2);
        exp_valid = !rst && !flush && (model_q.size() > 0);
        exp_count = rst ? 2'd0 : 2'(model_q.size());
        chk({tag, ".in_ready"},  {7'd0, bus.in_ready},  {7'd0, exp_ready});
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, exp_valid});
        chk({tag, ".count"},     {6'd0, bus.count},     {6'd0, exp_count});
        if (exp_valid) begin
            chk({tag, ".out_data"}, bus.out_data, model_q[0]);
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model at the edge.
    task automatic applyStimulus(input string tag, input logic r, input logic f,
                                 input logic iv, input logic [7:0] d, input logic ordy);
        logic accept;
        logic emit;
        @(negedge clk);
        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        checkOutput(tag);
        accept = !r && !f && iv && (model_q.size() < 2);
        emit   = !r && !f && ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (emit) void'(model_q.pop_front());
            if (accept) model_q.push_back(d);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        n_fail        = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hEE;
        bus.out_ready = 1'b0;
        @(posedge clk);

        // Reset held with a beat offered: nothing accepted or shown.
        applyStimulus("rst0", 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
        applyStimulus("rst1", 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);

        // Streaming 0x01..0x10 with the sink always ready.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("stream", 1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
        end
        applyStimulus("drain", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("idle",  1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure: fill, hold 0xA3 at the source, then release.
        applyStimulus("bp_a1",   1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        applyStimulus("bp_a2",   1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        applyStimulus("bp_a3",   1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
        applyStimulus("bp_hold", 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
        applyStimulus("bp_rel0", 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
        applyStimulus("bp_rel1", 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
        applyStimulus("bp_rel2", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("bp_done", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous accept and emit while in ONE.
        applyStimulus("sim_55",  1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        applyStimulus("sim_66",  1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        applyStimulus("sim_chk", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus("sim_out", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Source drops valid without an accept; data is ignored.
        applyStimulus("nov",     1'b0, 1'b0, 1'b0, 8'h99, 1'b1);

        // Mid-run reset from FULL discards both held beats.
        applyStimulus("mr_11",   1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        applyStimulus("mr_22",   1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus("mr_rst",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("mr_post0", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("mr_post1", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("mr_new",  1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        applyStimulus("mr_newo", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef STD_SKID_BUF_FLUSH_EN
        // Flush from FULL with a beat offered: not accepted, buffer empties.
        applyStimulus("fl_31",   1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
        applyStimulus("fl_32",   1'b0, 1'b0, 1'b1, 8'h32, 1'b0);
        applyStimulus("fl_on",   1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
        applyStimulus("fl_post", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("fl_new",  1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
        applyStimulus("fl_newo", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        applyStimulus("end", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
